// File: rtl/clock_pkg.sv
// Shared types and constants for the clock display output stage:
// shifter state encoding, 7-segment codes and segment bit positions.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    localparam int unsigned SEG_W  = 8;
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Segment patterns {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG7_0     = 7'h3F;
    localparam logic [6:0] SEG7_1     = 7'h06;
    localparam logic [6:0] SEG7_2     = 7'h5B;
    localparam logic [6:0] SEG7_3     = 7'h4F;
    localparam logic [6:0] SEG7_4     = 7'h66;
    localparam logic [6:0] SEG7_5     = 7'h6D;
    localparam logic [6:0] SEG7_6     = 7'h7D;
    localparam logic [6:0] SEG7_7     = 7'h07;
    localparam logic [6:0] SEG7_8     = 7'h7F;
    localparam logic [6:0] SEG7_9     = 7'h6F;
    localparam logic [6:0] SEG7_BLANK = 7'h00;

endpackage

// File: rtl/display_shift_driver_if.sv
// Core-to-display-driver bundle: frame request/data in, shift-chain pins out.
interface display_shift_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      start;
    logic [4*NUM_DIGITS-1:0]   digits_bcd;
    logic [NUM_DIGITS-1:0]     dp;
    logic                      blank_lead;
    logic                      busy;
    logic                      serial_out;
    logic                      clk_out;
    logic                      latch_out;

    modport master (
        output start, digits_bcd, dp, blank_lead,
        input  busy, serial_out, clk_out, latch_out
    );

    modport slave (
        input  start, digits_bcd, dp, blank_lead,
        output busy, serial_out, clk_out, latch_out
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit plus decimal point to {dp,g,f,e,d,c,b,a}.
// Non-decimal codes blank the segments but keep the decimal point.
module bcd_to_seg7
    import clock_pkg::*;
(
    input  logic [3:0]       bcd,
    input  logic             dp,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = '0;
        unique case (bcd)
            4'd0:    seg_c[SEG_G:SEG_A] = SEG7_0;
            4'd1:    seg_c[SEG_G:SEG_A] = SEG7_1;
            4'd2:    seg_c[SEG_G:SEG_A] = SEG7_2;
            4'd3:    seg_c[SEG_G:SEG_A] = SEG7_3;
            4'd4:    seg_c[SEG_G:SEG_A] = SEG7_4;
            4'd5:    seg_c[SEG_G:SEG_A] = SEG7_5;
            4'd6:    seg_c[SEG_G:SEG_A] = SEG7_6;
            4'd7:    seg_c[SEG_G:SEG_A] = SEG7_7;
            4'd8:    seg_c[SEG_G:SEG_A] = SEG7_8;
            4'd9:    seg_c[SEG_G:SEG_A] = SEG7_9;
            default: seg_c[SEG_G:SEG_A] = SEG7_BLANK;
        endcase
        seg_c[SEG_DP] = dp;
    end

endmodule

// File: rtl/display_shift_driver.sv
// Encodes the HH:MM digits to 7-segment and shifts the frame MSB first into
// an external 74HC595-style chain, finishing with a storage latch pulse.
module display_shift_driver
    import clock_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_DIV    = 2
) (
    input logic                   clk,
    input logic                   reset,
    display_shift_driver_if.slave bus
);

    localparam int unsigned FRAME_W = NUM_DIGITS * SEG_W;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned HP_W    = $clog2(CLK_DIV) + 1;
    localparam int unsigned TOP     = NUM_DIGITS - 1;

    logic [SEG_W-1:0]   seg_c [NUM_DIGITS];
    logic [FRAME_W-1:0] frame_c;

    state_t             state;
    logic [HP_W-1:0]    hp_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic               busy;
    logic               serial_out;
    logic               clk_out;
    logic               latch_out;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_enc
        bcd_to_seg7 u_enc (
            .bcd   (bus.digits_bcd[4*i +: 4]),
            .dp    (bus.dp[i]),
            .seg_c (seg_c[i])
        );
    end

    // Digit i lands in byte i, so the leading digit is shifted out first
    always_comb begin
        frame_c = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            frame_c[i*SEG_W +: SEG_W] = seg_c[i];
        end
        if (bus.blank_lead && (bus.digits_bcd[4*TOP +: 4] == 4'd0)) begin
            frame_c[TOP*SEG_W +: SEG_DP] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hp_cnt     <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            busy       <= 1'b0;
            serial_out <= 1'b0;
            clk_out    <= 1'b0;
            latch_out  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg      <= frame_c;
                        serial_out <= frame_c[FRAME_W-1];
                        hp_cnt     <= '0;
                        bit_cnt    <= '0;
                        busy       <= 1'b1;
                        state      <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (hp_cnt == HP_W'(CLK_DIV - 1)) begin
                        hp_cnt  <= '0;
                        clk_out <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        hp_cnt <= hp_cnt + HP_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (hp_cnt == HP_W'(CLK_DIV - 1)) begin
                        hp_cnt  <= '0;
                        clk_out <= 1'b0;
                        if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                            serial_out <= 1'b0;
                            latch_out  <= 1'b1;
                            state      <= LATCH;
                        end else begin
                            // Data changes together with the falling shift clock
                            shreg      <= {shreg[FRAME_W-2:0], 1'b0};
                            serial_out <= shreg[FRAME_W-2];
                            bit_cnt    <= bit_cnt + BIT_W'(1);
                            state      <= SHIFT_LO;
                        end
                    end else begin
                        hp_cnt <= hp_cnt + HP_W'(1);
                    end
                end
                LATCH: begin
                    if (hp_cnt == HP_W'(CLK_DIV - 1)) begin
                        hp_cnt    <= '0;
                        latch_out <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        hp_cnt <= hp_cnt + HP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.serial_out = serial_out;
    assign bus.clk_out    = clk_out;
    assign bus.latch_out  = latch_out;

endmodule
